// File: rtl/flash_prog_burst_ctrl.sv
// Flash program burst controller: streams op_num_words_i+1 FIFO words to
// consecutive flash addresses, with overflow/page checks, abort and drain.
module flash_prog_burst_ctrl #(
   parameter int unsigned AddrW     = 10,
   parameter int unsigned DataW     = 32,
   parameter int unsigned CntW      = 12,
   parameter int unsigned PageWords = 0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              op_start_i,
   input  logic [CntW-1:0]   op_num_words_i,
   input  logic [AddrW-1:0]  op_addr_i,
   input  logic              op_abort_i,
   output logic              op_busy_o,
   output logic              op_done_o,
   output logic              op_err_o,
   output logic [2:0]        op_err_code_o,
   output logic [CntW:0]     words_done_o,
   input  logic              data_rdy_i,
   input  logic [DataW-1:0]  data_i,
   output logic              data_rd_o,
   output logic              flash_req_o,
   output logic [AddrW-1:0]  flash_addr_o,
   output logic              flash_ovfl_o,
   output logic [DataW-1:0]  flash_data_o,
   input  logic              flash_done_i,
   input  logic              flash_error_i
);

   localparam int unsigned SumW = ((AddrW > CntW) ? AddrW : CntW) + 1;
   localparam logic [AddrW-1:0] PageMask = ~(AddrW'(PageWords) - AddrW'(1));

   localparam logic [2:0] CodeOk    = 3'd0;
   localparam logic [2:0] CodeFlash = 3'd1;
   localparam logic [2:0] CodeOvfl  = 3'd2;
   localparam logic [2:0] CodePage  = 3'd3;
   localparam logic [2:0] CodeAbort = 3'd4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PROG  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t             r_st, w_st_nxt;
   logic [CntW-1:0]    r_cnt, w_cnt_nxt;
   logic [AddrW-1:0]   r_base, w_base_nxt;
   logic [CntW-1:0]    r_num, w_num_nxt;
   logic [2:0]         r_code, w_code_nxt;
   logic               r_abort, w_abort_nxt;
   logic               r_hold, w_hold_nxt;
   logic [CntW:0]      r_words, w_words_nxt;

   logic [SumW-1:0]    w_sum_addr;
   logic [SumW-1:0]    w_end;
   logic               w_end_ovfl;
   logic               w_page_cross;
   logic               w_last;
   logic               w_req;
   logic               w_txn_done;
   logic               w_rd;
   logic               w_done;

   // Address path and start-time range checks, all in a width that cannot wrap
   assign w_sum_addr   = SumW'(r_base) + SumW'(r_cnt);
   assign w_end        = SumW'(op_addr_i) + SumW'(op_num_words_i);
   assign w_end_ovfl   = |w_end[SumW-1:AddrW];
   assign w_page_cross = (PageWords != 0) &&
                         (((op_addr_i ^ w_end[AddrW-1:0]) & PageMask) != '0);
   assign w_last       = (r_cnt == r_num);
   assign w_req        = (r_st == S_PROG) & ((data_rdy_i & ~r_abort) | r_hold);
   assign w_txn_done   = w_req & flash_done_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_st    <= S_IDLE;
         r_cnt   <= '0;
         r_base  <= '0;
         r_num   <= '0;
         r_code  <= CodeOk;
         r_abort <= 1'b0;
         r_hold  <= 1'b0;
         r_words <= '0;
      end else begin
         r_st    <= w_st_nxt;
         r_cnt   <= w_cnt_nxt;
         r_base  <= w_base_nxt;
         r_num   <= w_num_nxt;
         r_code  <= w_code_nxt;
         r_abort <= w_abort_nxt;
         r_hold  <= w_hold_nxt;
         r_words <= w_words_nxt;
      end
   end

   always_comb begin
      w_st_nxt    = r_st;
      w_cnt_nxt   = r_cnt;
      w_base_nxt  = r_base;
      w_num_nxt   = r_num;
      w_code_nxt  = r_code;
      w_abort_nxt = r_abort | (op_abort_i & (r_st != S_IDLE));
      w_hold_nxt  = r_hold;
      w_words_nxt = r_words;
      w_rd        = 1'b0;
      w_done      = 1'b0;

      unique case (r_st)
         S_IDLE: begin
            w_abort_nxt = 1'b0;
            if (op_start_i) begin
               w_base_nxt  = op_addr_i;
               w_num_nxt   = op_num_words_i;
               w_cnt_nxt   = '0;
               w_words_nxt = '0;
               w_hold_nxt  = 1'b0;
               w_code_nxt  = CodeOk;
               if (w_end_ovfl) begin
                  w_code_nxt = CodeOvfl;
                  w_st_nxt   = S_DRAIN;
               end else if (w_page_cross) begin
                  w_code_nxt = CodePage;
                  w_st_nxt   = S_DRAIN;
               end else begin
                  w_st_nxt   = S_PROG;
               end
            end
         end
         S_PROG: begin
            if (w_txn_done) begin
               w_rd       = 1'b1;
               w_hold_nxt = 1'b0;
               if (flash_error_i) begin
                  if (r_code == CodeOk) w_code_nxt = CodeFlash;
               end else begin
                  w_words_nxt = r_words + (CntW+1)'(1);
               end
               if (w_last) begin
                  w_done   = 1'b1;
                  w_st_nxt = S_IDLE;
               end else begin
                  w_cnt_nxt = r_cnt + CntW'(1);
                  // A pending abort waits for the in-flight word, then drains
                  if (flash_error_i || r_abort) begin
                     w_st_nxt = S_DRAIN;
                     if (!flash_error_i && r_code == CodeOk) w_code_nxt = CodeAbort;
                  end
               end
            end else if (w_req) begin
               w_hold_nxt = 1'b1;
            end else if (r_abort) begin
               w_st_nxt = S_DRAIN;
               if (r_code == CodeOk) w_code_nxt = CodeAbort;
            end
         end
         S_DRAIN: begin
            w_rd = data_rdy_i;
            if (data_rdy_i) begin
               if (w_last) begin
                  w_done   = 1'b1;
                  w_st_nxt = S_IDLE;
               end else begin
                  w_cnt_nxt = r_cnt + CntW'(1);
               end
            end
         end
         default: w_st_nxt = S_IDLE;
      endcase

      if (w_done) w_abort_nxt = 1'b0;
   end

   assign op_busy_o     = (r_st != S_IDLE);
   assign op_done_o     = w_done;
   assign op_err_o      = w_done & (w_code_nxt != CodeOk);
   assign op_err_code_o = w_done ? w_code_nxt : CodeOk;
   assign words_done_o  = w_done ? w_words_nxt : '0;
   assign data_rd_o     = w_rd;
   assign flash_req_o   = w_req;
   assign flash_addr_o  = w_sum_addr[AddrW-1:0];
   assign flash_ovfl_o  = |w_sum_addr[SumW-1:AddrW];
   assign flash_data_o  = data_i;

endmodule

// File: tb/tb_flash_prog_burst_ctrl.sv
// Directed bench for flash_prog_burst_ctrl: normal burst, overflow, page cross,
// flash error, abort mid-transaction and asynchronous reset mid-op.
module tb_flash_prog_burst_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, start_pg;
   logic [11:0] num;
   logic [9:0]  addr;
   logic        abort, rdy, fdone, ferr;
   logic [31:0] data;

   logic        busy, done, err, rd, req, ovfl;
   logic [2:0]  code;
   logic [12:0] words;
   logic [9:0]  faddr;
   logic [31:0] fdata;

   logic        pg_busy, pg_done, pg_err, pg_rd, pg_req, pg_ovfl;
   logic [2:0]  pg_code;
   logic [12:0] pg_words;
   logic [9:0]  pg_faddr;
   logic [31:0] pg_fdata;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   flash_prog_burst_ctrl u_dut (
      .clk_i(clk), .rst_i(rst), .op_start_i(start), .op_num_words_i(num),
      .op_addr_i(addr), .op_abort_i(abort), .op_busy_o(busy), .op_done_o(done),
      .op_err_o(err), .op_err_code_o(code), .words_done_o(words),
      .data_rdy_i(rdy), .data_i(data), .data_rd_o(rd), .flash_req_o(req),
      .flash_addr_o(faddr), .flash_ovfl_o(ovfl), .flash_data_o(fdata),
      .flash_done_i(fdone), .flash_error_i(ferr)
   );

   flash_prog_burst_ctrl #(.PageWords(16)) u_pg (
      .clk_i(clk), .rst_i(rst), .op_start_i(start_pg), .op_num_words_i(num),
      .op_addr_i(addr), .op_abort_i(abort), .op_busy_o(pg_busy), .op_done_o(pg_done),
      .op_err_o(pg_err), .op_err_code_o(pg_code), .words_done_o(pg_words),
      .data_rdy_i(rdy), .data_i(data), .data_rd_o(pg_rd), .flash_req_o(pg_req),
      .flash_addr_o(pg_faddr), .flash_ovfl_o(pg_ovfl), .flash_data_o(pg_fdata),
      .flash_done_i(fdone), .flash_error_i(ferr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; start_pg = 1'b0; num = '0; addr = '0;
      abort = 1'b0; rdy = 1'b0; fdone = 1'b0; ferr = 1'b0; data = '0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_req",  32'(req),  32'd0);
      chk("rst_addr", 32'(faddr), 32'd0);
      chk("rst_rd",   32'(rd),   32'd0);
      chk("rst_words", 32'(words), 32'd0);
      @(negedge clk); rst = 1'b0;

      // Normal 4-word burst; start and addr changes mid-op must be ignored
      @(negedge clk); start = 1'b1; addr = 10'h010; num = 12'd3; rdy = 1'b1; fdone = 1'b1;
      #1 chk("t1_idle_req", 32'(req), 32'd0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         start = (k == 1);
         addr  = (k == 1) ? 10'h200 : 10'h010;
         data  = 32'hA5A5_0000 + 32'(k);
         #1;
         chk("t1_req",  32'(req),   32'd1);
         chk("t1_addr", 32'(faddr), 32'h010 + 32'(k));
         chk("t1_rd",   32'(rd),    32'd1);
         chk("t1_data", fdata,      32'hA5A5_0000 + 32'(k));
         chk("t1_done", 32'(done),  32'(k == 3));
         if (k == 3) begin
            chk("t1_err",   32'(err),   32'd0);
            chk("t1_code",  32'(code),  32'd0);
            chk("t1_words", 32'(words), 32'd4);
         end
      end
      @(negedge clk); start = 1'b0; #1;
      chk("t1_busy_after", 32'(busy), 32'd0);
      chk("t1_done_after", 32'(done), 32'd0);

      // Address overflow: drained, code 2
      @(negedge clk); start = 1'b1; addr = 10'h3FE; num = 12'd3;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); start = 1'b0; #1;
         chk("t2_req",  32'(req),  32'd0);
         chk("t2_rd",   32'(rd),   32'd1);
         chk("t2_ovfl", 32'(ovfl), 32'(k >= 2));
         chk("t2_done", 32'(done), 32'(k == 3));
         if (k == 3) begin
            chk("t2_err",   32'(err),   32'd1);
            chk("t2_code",  32'(code),  32'd2);
            chk("t2_words", 32'(words), 32'd0);
         end
      end

      // Page crossing on the 16-word-page instance: code 3
      @(negedge clk); start_pg = 1'b1; addr = 10'h00E; num = 12'd3;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); start_pg = 1'b0; #1;
         chk("t3_req",  32'(pg_req),  32'd0);
         chk("t3_rd",   32'(pg_rd),   32'd1);
         chk("t3_done", 32'(pg_done), 32'(k == 3));
         if (k == 3) begin
            chk("t3_err",   32'(pg_err),   32'd1);
            chk("t3_code",  32'(pg_code),  32'd3);
            chk("t3_words", 32'(pg_words), 32'd0);
         end
      end

      // Flash error on word 2 of 8
      @(negedge clk); start = 1'b1; addr = 10'h000; num = 12'd7;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk); start = 1'b0; ferr = (k == 2); #1;
         chk("t4_req",  32'(req),  32'(k <= 2));
         chk("t4_rd",   32'(rd),   32'd1);
         chk("t4_done", 32'(done), 32'(k == 7));
         if (k == 7) begin
            chk("t4_err",   32'(err),   32'd1);
            chk("t4_code",  32'(code),  32'd1);
            chk("t4_words", 32'(words), 32'd2);
         end
      end
      @(negedge clk); ferr = 1'b0;

      // Slow PHY (done 3 cycles after req), abort during word 1
      start = 1'b1; addr = 10'h100; num = 12'd7; fdone = 1'b0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         start = 1'b0;
         fdone = ((k % 4) == 3);
         abort = (k == 5);
         #1;
         chk("t5_req",  32'(req),  32'(k <= 7));
         chk("t5_rd",   32'(rd),   32'((k == 3) || (k == 7) || (k >= 8 && k <= 13)));
         chk("t5_done", 32'(done), 32'(k == 13));
         chk("t5_busy", 32'(busy), 32'(k <= 13));
         if (k <= 7) chk("t5_addr", 32'(faddr), 32'h100 + 32'(k >= 4));
         if (k == 13) begin
            chk("t5_err",   32'(err),   32'd1);
            chk("t5_code",  32'(code),  32'd4);
            chk("t5_words", 32'(words), 32'd2);
         end
      end
      @(negedge clk); abort = 1'b0; fdone = 1'b1;

      // Asynchronous reset during word 2, then a fresh op from cnt 0
      start = 1'b1; addr = 10'h020; num = 12'd7;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); start = 1'b0; #1;
         chk("t6_req",  32'(req),   32'd1);
         chk("t6_addr", 32'(faddr), 32'h020 + 32'(k));
      end
      #1 rst = 1'b1;
      #1;
      chk("t6_rst_busy", 32'(busy), 32'd0);
      chk("t6_rst_req",  32'(req),  32'd0);
      chk("t6_rst_addr", 32'(faddr), 32'd0);
      chk("t6_rst_done", 32'(done), 32'd0);
      chk("t6_rst_rd",   32'(rd),   32'd0);
      @(negedge clk); rst = 1'b0; #1;
      chk("t6_idle_busy", 32'(busy), 32'd0);
      @(negedge clk); start = 1'b1; addr = 10'h040; num = 12'd1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk); start = 1'b0; #1;
         chk("t6_new_addr", 32'(faddr), 32'h040 + 32'(k));
         chk("t6_new_done", 32'(done),  32'(k == 1));
         if (k == 1) begin
            chk("t6_new_words", 32'(words), 32'd2);
            chk("t6_new_code",  32'(code),  32'd0);
         end
      end
      @(negedge clk); rdy = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
